// File: rtl/regfile_pkg.sv
// Register file shared definitions.
// Default geometry and the hardwired zero address.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the register file.
// Set wins over clear; busy lookups are registered per port.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              ra_busy,
  output logic              rb_busy
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);
  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic [NREG-1:0] r_pend;
  logic            r_ra_busy;
  logic            r_rb_busy;
  logic            w_clr;
  logic            w_set;
  logic            w_ra_busy;
  logic            w_rb_busy;

  assign w_clr = we && !(HAS_ZERO && wr_addr == ZA);
  assign w_set = sb_set && !(HAS_ZERO && sb_addr == ZA);

  // Pending vector: writeback clears, issue sets; set applied last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (w_clr) r_pend[wr_addr] <= 1'b0;
      if (w_set) r_pend[sb_addr] <= 1'b1;
    end
  end

  // Port A busy lookup with writeback bypass.
  always_comb begin
    w_ra_busy = r_pend[ra_addr];
    if (w_clr && wr_addr == ra_addr)
      w_ra_busy = w_set && sb_addr == ra_addr;
    if (HAS_ZERO && ra_addr == ZA)
      w_ra_busy = 1'b0;
  end

  // Port B busy lookup with writeback bypass.
  always_comb begin
    w_rb_busy = r_pend[rb_addr];
    if (w_clr && wr_addr == rb_addr)
      w_rb_busy = w_set && sb_addr == rb_addr;
    if (HAS_ZERO && rb_addr == ZA)
      w_rb_busy = 1'b0;
  end

  // Busy outputs are captured alongside the read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra_busy <= 1'b0;
      r_rb_busy <= 1'b0;
    end else if (rd_en) begin
      r_ra_busy <= w_ra_busy;
      r_rb_busy <= w_rb_busy;
    end
  end

  assign ra_busy = r_ra_busy;
  assign rb_busy = r_rb_busy;
endmodule

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with write bypass.
// Scoreboard tracks outstanding producers per register.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);
  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [NREG];
  logic [DATA_W-1:0] r_ra_data;
  logic [DATA_W-1:0] r_rb_data;
  logic [DATA_W-1:0] w_ra_val;
  logic [DATA_W-1:0] w_rb_val;
  logic              w_wr;

  assign w_wr = we && !(HAS_ZERO && wr_addr == ZA);

  // Data array: cleared on reset, written from writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Port A value with same-cycle writeback bypass.
  always_comb begin
    w_ra_val = r_mem[ra_addr];
    if (w_wr && wr_addr == ra_addr) w_ra_val = wr_data;
    if (HAS_ZERO && ra_addr == ZA) w_ra_val = '0;
  end

  // Port B value with same-cycle writeback bypass.
  always_comb begin
    w_rb_val = r_mem[rb_addr];
    if (w_wr && wr_addr == rb_addr) w_rb_val = wr_data;
    if (HAS_ZERO && rb_addr == ZA) w_rb_val = '0;
  end

  // Registered read data; holds when rd_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else if (rd_en) begin
      r_ra_data <= w_ra_val;
      r_rb_data <= w_rb_val;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .we      (we),
    .wr_addr (wr_addr),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .ra_busy (ra_busy),
    .rb_busy (rb_busy)
  );

  assign ra_data = r_ra_data;
  assign rb_data = r_rb_data;
endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench for regfile_bypass.
// Runs ZERO_REG=1 and ZERO_REG=0 builds side by side.
module tb_regfile_bypass;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic [31:0] ra_d [2];
  logic [31:0] rb_d [2];
  logic        ra_b [2];
  logic        rb_b [2];

  always #5 clk = ~clk;

  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[1]), .rb_data(rb_d[1]),
    .ra_busy(ra_b[1]), .rb_busy(rb_b[1]),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[0]), .rb_data(rb_d[0]),
    .ra_busy(ra_b[0]), .rb_busy(rb_b[0]),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  typedef struct packed {
    logic [31:0] a1, b1, a0, b0;
    logic        ab1, bb1, ab0, bb0;
  } exp_t;

  exp_t q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] m_mem  [2][32];
  logic        m_pend [2][32];
  logic [31:0] m_a  [2];
  logic [31:0] m_b  [2];
  logic        m_ab [2];
  logic        m_bb [2];

  function automatic void lookup(input int z, input int a,
                                 output logic [31:0] d,
                                 output logic b);
    if (z == 1 && a == 0) begin
      d = 0; b = 0;
    end else if (we && int'(wr_addr) == a) begin
      d = wr_data;
      b = sb_set && int'(sb_addr) == a;
    end else begin
      d = m_mem[z][a]; b = m_pend[z][a];
    end
  endfunction

  // Reference model: one expected output set per clock edge.
  initial begin
    exp_t e;
    for (int z = 0; z < 2; z++) begin
      m_a[z] = 0; m_b[z] = 0; m_ab[z] = 0; m_bb[z] = 0;
      for (int i = 0; i < 32; i++) begin
        m_mem[z][i] = 0; m_pend[z][i] = 0;
      end
    end
    forever begin
      @(posedge clk);
      for (int z = 0; z < 2; z++) begin
        if (rst) begin
          m_a[z] = 0; m_b[z] = 0; m_ab[z] = 0; m_bb[z] = 0;
          for (int i = 0; i < 32; i++) begin
            m_mem[z][i] = 0; m_pend[z][i] = 0;
          end
        end else begin
          if (rd_en) begin
            lookup(z, int'(ra_addr), m_a[z], m_ab[z]);
            lookup(z, int'(rb_addr), m_b[z], m_bb[z]);
          end
          if (we && !(z == 1 && wr_addr == 0)) begin
            m_mem[z][wr_addr] = wr_data;
            m_pend[z][wr_addr] = 0;
          end
          if (sb_set && !(z == 1 && sb_addr == 0))
            m_pend[z][sb_addr] = 1;
        end
      end
      e.a1 = m_a[1]; e.b1 = m_b[1]; e.ab1 = m_ab[1]; e.bb1 = m_bb[1];
      e.a0 = m_a[0]; e.b0 = m_b[0]; e.ab0 = m_ab[0]; e.bb0 = m_bb[0];
      q.push_back(e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h",
                  nm, $time, act, exp);
  endtask

  // Monitor: compare DUT outputs against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("z1_ra_data", ra_d[1], e.a1);
        chk("z1_rb_data", rb_d[1], e.b1);
        chk("z1_ra_busy", 32'(ra_b[1]), 32'(e.ab1));
        chk("z1_rb_busy", 32'(rb_b[1]), 32'(e.bb1));
        chk("z0_ra_data", ra_d[0], e.a0);
        chk("z0_rb_data", rb_d[0], e.b0);
        chk("z0_ra_busy", 32'(ra_b[0]), 32'(e.ab0));
        chk("z0_rb_busy", 32'(rb_b[0]), 32'(e.bb0));
      end
    end
  end

  task automatic step(input logic r, input logic re,
                      input int a, input int b,
                      input logic w, input int wa,
                      input logic [31:0] wd,
                      input logic s, input int sa);
    rst = r; rd_en = re;
    ra_addr = 5'(a); rb_addr = 5'(b);
    we = w; wr_addr = 5'(wa); wr_data = wd;
    sb_set = s; sb_addr = 5'(sa);
    @(negedge clk);
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 31, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step(0, 1, 5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 3, 4, 0, 0, 0, 0, 0);
    step(0, 1, 7, 7, 1, 7, 32'h12345678, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9);
    step(0, 1, 9, 9, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 32'h55, 1, 9);
    step(0, 1, 9, 9, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 32'h66, 0, 0);
    step(0, 1, 9, 9, 0, 0, 0, 0, 0);
    step(0, 1, 9, 9, 1, 9, 32'h77, 1, 9);
    step(0, 0, 0, 0, 1, 3, 32'hA5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(1, 1, 3, 3, 1, 3, 32'h11, 1, 3);
    step(0, 1, 3, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                       : int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                       : int'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, 7)),
           $urandom(),
           ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 7)));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d left expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised general-purpose register file for the single-cycle/pipelined datapath: two registered read ports, one write port with same-cycle write-to-read bypass, a hardwired zero register and a per-register pending-write scoreboard for hazard detection. It sits between the decode stage (register addresses, scoreboard set) and writeback (write port), and feeds operands to the ALU stage.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read enable; captures both read ports this cycle
- ra_addr  in  ADDR_W  read port A address (rs)
- rb_addr  in  ADDR_W  read port B address (rt)
- ra_data  out  DATA_W  port A data, registered
- rb_data  out  DATA_W  port B data, registered
- ra_busy  out  1  port A register has pending write, registered with ra_data
- rb_busy  out  1  port B register has pending write, registered with rb_data
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address (rd)
- wr_data  in  DATA_W  write data
- sb_set  in  1  mark sb_addr pending (producer issued)
- sb_addr  in  ADDR_W  register to mark pending

## Operation
- Storage: NREG x DATA_W array plus NREG-bit pending vector pend[].
- Write: on edge with we=1, mem[wr_addr] <= wr_data and pend[wr_addr] <= 0.
- Scoreboard set: on edge with sb_set=1, pend[sb_addr] <= 1.
- sb_set and we to same address same cycle: set wins, pend stays 1 (new producer outstanding); data still written.
- Read: on edge with rd_en=1, ra_data <= value(ra_addr), ra_busy <= busy(ra_addr); same for B. rd_en=0: outputs hold previous values.
- Bypass: if we=1 and wr_addr == ra_addr in the read cycle, value = wr_data and busy = 0 (unless sb_set to same address also that cycle, then busy = 1). Same independently for B.
- ZERO_REG=1: writes and sb_set to address 0 ignored; reads of 0 return 0, busy 0, no bypass.
- Both read ports may address the same register; both return identical data.
- Reset: all mem entries 0, pend all 0, ra_data/rb_data 0, ra_busy/rb_busy 0. rst overrides we, sb_set and rd_en in the same cycle.

## Timing
- Read latency 1 cycle: address at edge N, data valid after edge N.
- Write visible to a read sampled in the same cycle (bypass), so writeback-to-read needs no stall.
- Scoreboard set at edge N affects busy for reads sampled at edge N+1 onward; same-cycle sb_set/read to the same address returns the pre-set pend value, except as specified under Bypass.
- No combinational path from inputs to outputs.
- Reset asserted mid-operation: state cleared at that edge; first read after deassertion returns 0 for every address.

## Structure
- Shared package regfile_pkg: default DATA_W, ADDR_W, constant ZERO_ADDR = 0.
- Sub-module reg_scoreboard: pend[] vector with set/clear/priority logic and two registered busy lookups (with bypass-clear); regfile_bypass instantiates it alongside the data array and read/bypass muxes.
- Read-port logic written once per port, no shared mux state between ports.

## Test plan
- Reset, then rd_en with ra_addr=5, rb_addr=31 -> ra_data=0, rb_data=0, both busy=0.
- Write r5=0xDEADBEEF, next cycle read A=5 -> ra_data=0xDEADBEEF one cycle later; rd_en=0 following cycles -> output holds.
- Same cycle we r7=0x12345678 and read A=7, B=7 -> both data 0x12345678, busy 0 (bypass).
- Write r0=0xFFFFFFFF and sb_set r0 (ZERO_REG=1) -> read r0 returns 0, busy 0; ZERO_REG=0 build returns 0xFFFFFFFF.
- sb_set r9, next cycle read 9 -> busy 1; then we r9=0x55 together with sb_set r9 -> read shows data 0x55, busy 1; we r9 alone -> busy 0.
- Write r3=0xA5, sb_set r3, assert rst with we r3=0x11 -> read r3 returns 0, busy 0.
